// File: rtl/keypad_entry_pkg.sv
// Shared constants and types for the keypad entry block.
// Command key codes, digit capacity and press-qualifier state encoding.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  localparam int MAX_DIGITS = 4;

  typedef enum logic [1:0] {
    Q_ARMED   = 2'd0,
    Q_HELD    = 2'd1,
    Q_RELEASE = 2'd2
  } qual_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/press_qualifier.sv
// Converts the level-style key_press into one accept pulse per physical press.
// A new press is only accepted after RELEASE_CYCLES consecutive low cycles.
//
// state     | meaning
// ----------+---------------------------------------------------------
// Q_ARMED   | released long enough; next high key_press is accepted
// Q_HELD    | key down (or held through reset); waiting for release
// Q_RELEASE | key up, counting consecutive low cycles toward re-arm
module press_qualifier
  import keypad_entry_pkg::*;
#(
  parameter int RELEASE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_press,
  input  logic [3:0] key_value,
  output logic       accept,
  output logic [3:0] accepted_value
);

  localparam int CW = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  qual_state_t   state, state_nxt;
  logic [CW-1:0] rel_cnt, rel_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= Q_HELD;
      rel_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rel_cnt <= rel_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rel_cnt_nxt = rel_cnt;
    accept      = 1'b0;
    case (state)
      Q_ARMED: begin
        if (key_press) begin
          accept    = 1'b1;
          state_nxt = Q_HELD;
        end
      end
      Q_HELD: begin
        if (!key_press) begin
          rel_cnt_nxt = CW'(1);
          state_nxt   = (RELEASE_CYCLES <= 1) ? Q_ARMED : Q_RELEASE;
        end
      end
      Q_RELEASE: begin
        // A bounce back high restarts the release qualification from HELD.
        if (key_press) begin
          state_nxt   = Q_HELD;
          rel_cnt_nxt = '0;
        end else if (rel_cnt == REL_LAST) begin
          state_nxt = Q_ARMED;
        end else begin
          rel_cnt_nxt = rel_cnt + CW'(1);
        end
      end
      default: state_nxt = Q_HELD;
    endcase
  end

  assign accepted_value = key_value;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry assembler: builds a 4-digit BCD word from qualified key presses,
// with backspace/clear/enter commands and an inactivity auto-clear.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_value,
  input  logic        key_press,
  output logic [15:0] entry,
  output logic [2:0]  digit_count,
  output logic [15:0] entry_data,
  output logic        entry_valid,
  output logic        entry_error,
  output logic        timeout
);

  localparam int TW = (TIMEOUT_CYCLES < 3) ? 1 : $clog2(TIMEOUT_CYCLES);
  // Expiry fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

  logic          accept;
  logic [3:0]    accepted_value;
  logic [TW-1:0] idle_cnt;

  press_qualifier #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_qual (
    .clk           (clk),
    .reset         (reset),
    .key_press     (key_press),
    .key_value     (key_value),
    .accept        (accept),
    .accepted_value(accepted_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      entry       <= '0;
      digit_count <= '0;
      entry_data  <= '0;
      entry_valid <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      entry_valid <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
      if (accept) begin
        idle_cnt <= '0;
        if (is_digit(accepted_value)) begin
          if (digit_count < 3'(MAX_DIGITS)) begin
            entry       <= {entry[11:0], accepted_value};
            digit_count <= digit_count + 3'd1;
          end else begin
            entry_error <= 1'b1;
          end
        end else if (accepted_value == KEY_BKSP) begin
          if (digit_count != 3'd0) begin
            entry       <= {4'h0, entry[15:4]};
            digit_count <= digit_count - 3'd1;
          end
        end else if (accepted_value == KEY_CLR) begin
          entry       <= '0;
          digit_count <= '0;
        end else if (accepted_value == KEY_ENTER) begin
          if (digit_count != 3'd0) begin
            entry_data  <= entry;
            entry_valid <= 1'b1;
            entry       <= '0;
            digit_count <= '0;
          end else begin
            entry_error <= 1'b1;
          end
        end
      end else if (digit_count == 3'd0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == T_LAST) begin
        entry       <= '0;
        digit_count <= '0;
        timeout     <= 1'b1;
        idle_cnt    <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule
